// File: rtl/glitch_pkg.sv
// Shared types and constants for the glitch sequencer slice.
package glitch_pkg;

  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned REP_W_DEF = 4;

  // Decoded I2C word layout: [8:1] data byte, [0] ack (0) / nack (1).
  localparam int unsigned DEC_W    = 9;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned BYTE_MSB = 8;
  localparam int unsigned BYTE_LSB = 1;
  localparam int unsigned ACK_BIT  = 0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    DELAY  = 3'd2,
    GLITCH = 3'd3,
    GAP    = 3'd4,
    DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/i2c_byte_match.sv
// Selects one sniffer bus and flags a strobed byte equal to the match value.
module i2c_byte_match
  import glitch_pkg::*;
#(
  parameter bit REQ_ACK = 1'b1
) (
  input  logic [DEC_W-1:0]  main_sda_dec,
  input  logic              main_ready,
  input  logic [DEC_W-1:0]  priv_sda_dec,
  input  logic              priv_ready,
  input  logic              bus_sel,
  input  logic [BYTE_W-1:0] match_byte,
  output logic              match_c
);

  logic [DEC_W-1:0] sel_dec;
  logic             sel_ready;

  // Only the selected bus is looked at; the other one is ignored entirely.
  always_comb begin
    sel_dec   = bus_sel ? priv_sda_dec : main_sda_dec;
    sel_ready = bus_sel ? priv_ready   : main_ready;
    match_c   = sel_ready
             && (sel_dec[BYTE_MSB:BYTE_LSB] == match_byte)
             && (!REQ_ACK || !sel_dec[ACK_BIT]);
  end

endmodule

// File: rtl/glitch_sequencer.sv
// DAC level arbiter: passes pmic_level through, or overrides it with a
// programmed glitch pulse train triggered by a matching I2C byte.
module glitch_sequencer
  import glitch_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned REP_W   = REP_W_DEF,
  parameter bit          REQ_ACK = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DEC_W-1:0]  main_sda_dec,
  input  logic              main_ready,
  input  logic [DEC_W-1:0]  priv_sda_dec,
  input  logic              priv_ready,
  input  logic [BYTE_W-1:0] pmic_level,
  input  logic              arm,
  input  logic              abort,
  input  logic              cfg_bus_sel,
  input  logic [BYTE_W-1:0] cfg_match,
  input  logic [CNT_W-1:0]  cfg_delay,
  input  logic [CNT_W-1:0]  cfg_width,
  input  logic [CNT_W-1:0]  cfg_gap,
  input  logic [REP_W-1:0]  cfg_repeat,
  input  logic [BYTE_W-1:0] cfg_level,
  output logic [BYTE_W-1:0] dac_level,
  output logic              glitch_active,
  output logic              busy,
  output logic              done
);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [REP_W-1:0]    rem_q, rem_d;

  logic                sel_q, sel_d;
  logic [BYTE_W-1:0]   match_q, match_d;
  logic [CNT_W-1:0]    delay_q, delay_d;
  logic [CNT_W-1:0]    width_q, width_d;
  logic [CNT_W-1:0]    gap_q, gap_d;
  logic [BYTE_W-1:0]   level_q, level_d;

  logic [BYTE_W-1:0]   dac_d;
  logic                glitch_d, busy_d, done_d;
  logic                match_c;

  i2c_byte_match #(
    .REQ_ACK (REQ_ACK)
  ) u_match (
    .main_sda_dec (main_sda_dec),
    .main_ready   (main_ready),
    .priv_sda_dec (priv_sda_dec),
    .priv_ready   (priv_ready),
    .bus_sel      (sel_q),
    .match_byte   (match_q),
    .match_c      (match_c)
  );

  // State, counters, latched config and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rem_q         <= '0;
      sel_q         <= 1'b0;
      match_q       <= '0;
      delay_q       <= '0;
      width_q       <= '0;
      gap_q         <= '0;
      level_q       <= '0;
      dac_level     <= '0;
      glitch_active <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rem_q         <= rem_d;
      sel_q         <= sel_d;
      match_q       <= match_d;
      delay_q       <= delay_d;
      width_q       <= width_d;
      gap_q         <= gap_d;
      level_q       <= level_d;
      dac_level     <= dac_d;
      glitch_active <= glitch_d;
      busy          <= busy_d;
      done          <= done_d;
    end
  end

  // Next-state, counter and output decode; abort overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    sel_d   = sel_q;
    match_d = match_q;
    delay_d = delay_q;
    width_d = width_q;
    gap_d   = gap_q;
    level_d = level_q;

    case (state_q)
      IDLE: begin
        if (arm && !abort) begin
          sel_d   = cfg_bus_sel;
          match_d = cfg_match;
          delay_d = cfg_delay;
          width_d = (cfg_width  == '0) ? CNT_W'(1) : cfg_width;
          gap_d   = (cfg_gap    == '0) ? CNT_W'(1) : cfg_gap;
          rem_d   = (cfg_repeat == '0) ? REP_W'(1) : cfg_repeat;
          level_d = cfg_level;
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (match_c) begin
          state_d = DELAY;
          cnt_d   = delay_q;
        end
      end
      DELAY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = GLITCH;
          cnt_d   = width_q - CNT_W'(1);
        end
      end
      GLITCH: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (rem_q > REP_W'(1)) begin
          rem_d   = rem_q - REP_W'(1);
          state_d = GAP;
          cnt_d   = gap_q - CNT_W'(1);
        end else begin
          state_d = DONE;
        end
      end
      GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = GLITCH;
          cnt_d   = width_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort) begin
      state_d = IDLE;
    end

    // Outputs follow the state being entered so they line up with it.
    glitch_d = (state_d == GLITCH);
    dac_d    = glitch_d ? level_q : pmic_level;
    busy_d   = (state_d != IDLE) && (state_d != DONE);
    done_d   = (state_d == DONE);
  end

endmodule

// File: tb/tb_glitch_sequencer.sv
// Directed self-checking bench for glitch_sequencer.
module tb_glitch_sequencer;

  logic        clk;
  logic        rst_n;
  logic [8:0]  main_sda_dec;
  logic        main_ready;
  logic [8:0]  priv_sda_dec;
  logic        priv_ready;
  logic [7:0]  pmic_level;
  logic        arm;
  logic        abort;
  logic        cfg_bus_sel;
  logic [7:0]  cfg_match;
  logic [15:0] cfg_delay;
  logic [15:0] cfg_width;
  logic [15:0] cfg_gap;
  logic [3:0]  cfg_repeat;
  logic [7:0]  cfg_level;
  logic [7:0]  dac_level;
  logic        glitch_active;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  glitch_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .main_sda_dec  (main_sda_dec),
    .main_ready    (main_ready),
    .priv_sda_dec  (priv_sda_dec),
    .priv_ready    (priv_ready),
    .pmic_level    (pmic_level),
    .arm           (arm),
    .abort         (abort),
    .cfg_bus_sel   (cfg_bus_sel),
    .cfg_match     (cfg_match),
    .cfg_delay     (cfg_delay),
    .cfg_width     (cfg_width),
    .cfg_gap       (cfg_gap),
    .cfg_repeat    (cfg_repeat),
    .cfg_level     (cfg_level),
    .dac_level     (dac_level),
    .glitch_active (glitch_active),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one active edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic sel, input logic [7:0] m, input logic [15:0] dly,
                         input logic [15:0] wid, input logic [15:0] gp,
                         input logic [3:0] rep, input logic [7:0] lvl);
    cfg_bus_sel = sel;
    cfg_match   = m;
    cfg_delay   = dly;
    cfg_width   = wid;
    cfg_gap     = gp;
    cfg_repeat  = rep;
    cfg_level   = lvl;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // One-cycle strobe on either bus; the tick here is edge E0.
  task automatic strobe(input logic on_priv, input logic [7:0] b, input logic nack);
    if (on_priv) begin
      priv_sda_dec = {b, nack};
      priv_ready   = 1'b1;
    end else begin
      main_sda_dec = {b, nack};
      main_ready   = 1'b1;
    end
    tick();
    main_ready = 1'b0;
    priv_ready = 1'b0;
  endtask

  // Runs several cycles and confirms no glitch ever appeared.
  task automatic expect_quiet(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      seen = seen | glitch_active | done;
    end
    check(tag, seen, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    main_sda_dec = '0; main_ready = 1'b0;
    priv_sda_dec = '0; priv_ready = 1'b0;
    pmic_level = 8'h40;
    arm = 1'b0; abort = 1'b0;
    set_cfg(1'b0, 8'h00, 16'd0, 16'd1, 16'd1, 4'd1, 8'h00);

    // 1. Reset state and pass-through latency.
    tick(); tick();
    check("rst dac", dac_level, 8'h00);
    check("rst busy", busy, 0);
    check("rst glitch", glitch_active, 0);
    check("rst done", done, 0);
    rst_n = 1'b1;
    tick();
    check("post-rst dac", dac_level, 8'h40);

    // 2. Single pulse; config changes after arm must not matter.
    set_cfg(1'b0, 8'h4A, 16'd3, 16'd2, 16'd1, 4'd1, 8'hFF);
    do_arm();
    check("t2 armed busy", busy, 1);
    set_cfg(1'b1, 8'h00, 16'd0, 16'd9, 16'd1, 4'd5, 8'h11);
    strobe(1'b0, 8'h4A, 1'b0);
    check("t2 E0 dac", dac_level, 8'h40);
    for (int i = 1; i <= 7; i++) begin
      tick();
      check($sformatf("t2 dac E%0d", i), dac_level, (i == 4 || i == 5) ? 8'hFF : 8'h40);
      check($sformatf("t2 glitch E%0d", i), glitch_active, (i == 4 || i == 5) ? 1 : 0);
      check($sformatf("t2 done E%0d", i), done, (i == 6) ? 1 : 0);
    end
    check("t2 idle busy", busy, 0);

    // 3. Repeated pulses with gaps.
    set_cfg(1'b0, 8'h55, 16'd0, 16'd1, 16'd2, 4'd3, 8'hA5);
    do_arm();
    strobe(1'b0, 8'h55, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      tick();
      check($sformatf("t3 dac E%0d", i), dac_level,
            (i == 1 || i == 4 || i == 7) ? 8'hA5 : 8'h40);
      check($sformatf("t3 done E%0d", i), done, (i == 8) ? 1 : 0);
      check($sformatf("t3 busy E%0d", i), busy, (i <= 7) ? 1 : 0);
    end

    // 4. Bus selection and NACK filtering.
    set_cfg(1'b1, 8'h30, 16'd5, 16'd1, 16'd1, 4'd1, 8'h77);
    do_arm();
    strobe(1'b0, 8'h30, 1'b0);
    expect_quiet("t4 main ignored", 8);
    strobe(1'b1, 8'h30, 1'b1);
    expect_quiet("t4 nack ignored", 8);
    main_sda_dec = {8'h30, 1'b0};
    main_ready = 1'b1;
    strobe(1'b1, 8'h31, 1'b0);
    expect_quiet("t4 both buses wrong byte", 8);
    check("t4 still armed", busy, 1);
    strobe(1'b1, 8'h30, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("t4 glitch E%0d", i), glitch_active, (i == 6) ? 1 : 0);
      check($sformatf("t4 done E%0d", i), done, (i == 7) ? 1 : 0);
    end

    // 5. Abort on the 4th glitch cycle, then no retrigger without arm.
    set_cfg(1'b0, 8'h12, 16'd1, 16'd10, 16'd1, 4'd1, 8'hEE);
    do_arm();
    strobe(1'b0, 8'h12, 1'b0);
    tick();
    for (int i = 2; i <= 5; i++) begin
      tick();
      check($sformatf("t5 dac E%0d", i), dac_level, 8'hEE);
    end
    abort = 1'b1;
    pmic_level = 8'h3C;
    tick();
    abort = 1'b0;
    check("t5 abort dac", dac_level, 8'h3C);
    check("t5 abort glitch", glitch_active, 0);
    check("t5 abort busy", busy, 0);
    check("t5 abort done", done, 0);
    expect_quiet("t5 no done after abort", 4);
    strobe(1'b0, 8'h12, 1'b0);
    expect_quiet("t5 no retrigger", 14);
    check("t5 idle busy", busy, 0);

    // 6. Zero coercion, then arm+abort collision.
    set_cfg(1'b0, 8'h66, 16'd0, 16'd0, 16'd0, 4'd0, 8'h99);
    do_arm();
    strobe(1'b0, 8'h66, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("t6 dac E%0d", i), dac_level, (i == 1) ? 8'h99 : 8'h3C);
      check($sformatf("t6 done E%0d", i), done, (i == 2) ? 1 : 0);
    end
    arm = 1'b1;
    abort = 1'b1;
    tick();
    arm = 1'b0;
    abort = 1'b0;
    check("t6 collision busy", busy, 0);
    strobe(1'b0, 8'h66, 1'b0);
    expect_quiet("t6 collision no arm", 4);

    // Reset asserted mid-pulse clears outputs without a clock.
    set_cfg(1'b0, 8'h21, 16'd0, 16'd10, 16'd1, 4'd1, 8'hC3);
    do_arm();
    strobe(1'b0, 8'h21, 1'b0);
    tick();
    check("mid-pulse dac", dac_level, 8'hC3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst dac", dac_level, 8'h00);
    check("async rst glitch", glitch_active, 0);
    check("async rst busy", busy, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("after rst dac", dac_level, 8'h3C);
    strobe(1'b0, 8'h21, 1'b0);
    expect_quiet("after rst not armed", 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
